main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
Memory-side responder for the cache-to-main-memory line protocol (mem_read / mem_write / ca_resp). It accepts one line-sized read or write request from the cache controller and models access latency followed by a word-serial burst into or out of a word-organised backing store. On completion it pulses ca_resp, then holds the read line stable so the cache can load it after ca_resp falls.

Parameters:
ADDR_WIDTH, 32, byte address width of mem_addr
WORD_BITS, 32, backing-store word width
LINE_BITS, 256, cache line width; must be a multiple of WORD_BITS (WPL = LINE_BITS/WORD_BITS = 8)
DEPTH_LINES, 1024, number of lines in the store; power of two
LATENCY, 4, idle access cycles before the burst; 0 allowed

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  level request: read line at mem_addr
mem_write  in  1  level request: write mem_wdata to line at mem_addr
mem_addr  in  ADDR_WIDTH  byte address; line offset bits ignored
mem_wdata  in  LINE_BITS  write line; sampled only on the accept edge
mem_rdata  out  LINE_BITS  read line; valid from the ca_resp cycle until the next read accept
ca_resp  out  1  single-cycle completion pulse
busy  out  1  high in every state except IDLE
err  out  1  sticky protocol-error flag; cleared only by rst

Behaviour:
- Reset (async): state=IDLE, ca_resp=0, busy=0, err=0, mem_rdata=0, counters=0. Store contents are not reset.
- Line index = mem_addr[log2(LINE_BITS/8) +: log2(DEPTH_LINES)]. Higher bits are ignored, so indices wrap modulo DEPTH_LINES.
- States: IDLE, ACCESS, BURST, RESP, GAP.
- IDLE: accepts a request on an edge where mem_read|mem_write=1.
  - Latches the index, the op, and (for writes) mem_wdata into the line buffer.
  - Goes to ACCESS with lat_cnt=0, or to BURST directly if LATENCY=0.
  - Both mem_read and mem_write high: the write wins and err is set.
- ACCESS: lat_cnt increments each cycle. At lat_cnt=LATENCY-1, go to BURST with word_cnt=0.
- BURST: one word per cycle, lowest word first. word_cnt wraps 0..WPL-1.
  - Write: the store word at (index, word_cnt) gets buffer word word_cnt.
  - Read: buffer word word_cnt gets the store word. The buffer is a separate read staging register; mem_rdata is not disturbed mid-burst.
  - At word_cnt=WPL-1: go to RESP. A read also copies the completed buffer into mem_rdata on this edge.
- RESP: ca_resp=1 for exactly this cycle, then GAP.
- GAP: ignores all requests for exactly one cycle, then IDLE. This is required because the cache keeps mem_read asserted for one cycle after seeing ca_resp.
- Total latency: ca_resp is high in the cycle following accept edge + LATENCY + WPL edges. Default = 12 cycles after the accept edge.
- Abort: if the active op's request input drops during ACCESS or BURST:
  - set err and return to IDLE; no ca_resp;
  - words already written remain committed;
  - mem_rdata is unchanged.
- The request input changing op mid-transaction (read to write or the reverse) is treated as an abort.
- mem_wdata changes after the accept edge have no effect.
- Back-to-back: write-back then fill (mem_write released, mem_read asserted the next cycle) lands in GAP. The read is accepted one cycle later. No request is lost.

Decomposition:
- Package mem_pkg: resp_state_t enum (IDLE, ACCESS, BURST, RESP, GAP), WPL and offset/index width localparams, and the helper function line_index(addr).
- Sub-module mem_word_array: DEPTH_LINES*WPL words of WORD_BITS, asynchronous read, synchronous write enable, no reset.
- The responder FSM, counters and line buffers are in main_mem_responder.

Test Plan:
- Read timing: preload line 5 with words 0x1000_0000+i. Hold mem_read, addr=0x0000_00A0. Required: ca_resp high exactly 12 cycles after the accept edge, for one cycle; mem_rdata word i = 0x1000_0000+i; busy low after GAP.
- Write then read-back: write line 0xDEAD_0000+i to addr 0x40 and wait for ca_resp. Read addr 0x40. Required: identical line returned; adjacent lines 1 and 3 unchanged.
- Cache sequence: mem_write held through ca_resp, then mem_read next cycle and held one cycle after its ca_resp. Required: exactly two transactions, two ca_resp pulses, err=0, no third accept.
- Abort: drop mem_read 3 cycles into BURST. Required: err=1, no ca_resp, mem_rdata keeps its prior value, state IDLE on the next edge.
- Conflict and wrap: mem_read=mem_write=1 with addr = DEPTH_LINES*32 + 0x20. Required: a write to line 1, err=1. Repeat with LATENCY=0: ca_resp 8 cycles after accept.
- Async reset mid-ACCESS: assert rst between clock edges. Required: ca_resp=busy=err=0 immediately; store contents from earlier writes intact on a subsequent read.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, default geometry and address helper for the main memory responder
package mem_pkg;

  typedef enum logic [2:0] {IDLE, ACCESS, BURST, RESP, GAP} resp_state_t;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_WORD_BITS   = 32;
  localparam int DEF_LINE_BITS   = 256;
  localparam int DEF_DEPTH_LINES = 1024;
  localparam int DEF_LATENCY     = 4;

  localparam int WPL   = DEF_LINE_BITS / DEF_WORD_BITS;
  localparam int OFF_W = $clog2(DEF_LINE_BITS / 8);
  localparam int IDX_W = $clog2(DEF_DEPTH_LINES);

  // Line index for the default geometry; upper address bits wrap.
  function automatic logic [IDX_W-1:0] line_index(input logic [DEF_ADDR_WIDTH-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word-organised backing store, async read, sync write, no reset
module mem_word_array #(
  parameter int WORD_BITS   = 32,
  parameter int DEPTH_WORDS = 8192,
  parameter int AW          = 13
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  output logic [WORD_BITS-1:0] rdata_o
);

  logic [WORD_BITS-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - line-level read/write responder: access latency, word burst, ca_resp pulse
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WORD_BITS   = DEF_WORD_BITS,
  parameter int LINE_BITS   = DEF_LINE_BITS,
  parameter int DEPTH_LINES = DEF_DEPTH_LINES,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [LINE_BITS-1:0]  mem_wdata,
  output logic [LINE_BITS-1:0]  mem_rdata,
  output logic                  ca_resp,
  output logic                  busy,
  output logic                  err
);

  localparam int WPL_L = LINE_BITS / WORD_BITS;
  localparam int OFF_L = $clog2(LINE_BITS / 8);
  localparam int IDX_L = $clog2(DEPTH_LINES);
  localparam int WC_W  = (WPL_L > 1) ? $clog2(WPL_L) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WPL_L - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  resp_state_t          state_q;
  logic                 op_wr_q;
  logic [IDX_L-1:0]     idx_q;
  logic [LAT_W-1:0]     lat_cnt_q;
  logic [WC_W-1:0]      word_cnt_q;
  logic [LINE_BITS-1:0] line_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic                 resp_q;
  logic                 busy_q;
  logic                 err_q;

  logic [IDX_L-1:0]     req_idx;
  logic                 req_ok;
  logic                 store_we;
  logic [WORD_BITS-1:0] store_wword;
  logic [WORD_BITS-1:0] store_rword;
  logic [LINE_BITS-1:0] line_fill;
  logic                 unused_addr_bits;

  assign req_idx          = mem_addr[OFF_L +: IDX_L];
  assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:OFF_L+IDX_L], mem_addr[OFF_L-1:0]};

  // A read is only kept alive while mem_write stays low; flipping to a write aborts it.
  assign req_ok      = op_wr_q ? mem_write : (mem_read && !mem_write);
  assign store_we    = (state_q == BURST) && op_wr_q && req_ok;
  assign store_wword = line_q[word_cnt_q*WORD_BITS +: WORD_BITS];

  always_comb begin
    line_fill = line_q;
    line_fill[word_cnt_q*WORD_BITS +: WORD_BITS] = store_rword;
  end

  mem_word_array #(
    .WORD_BITS  (WORD_BITS),
    .DEPTH_WORDS(DEPTH_LINES * WPL_L),
    .AW         (IDX_L + WC_W)
  ) u_array (
    .clk_i  (clk),
    .we_i   (store_we),
    .addr_i ({idx_q, word_cnt_q}),
    .wdata_i(store_wword),
    .rdata_o(store_rword)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      lat_cnt_q  <= '0;
      word_cnt_q <= '0;
      line_q     <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            op_wr_q    <= mem_write;
            idx_q      <= req_idx;
            lat_cnt_q  <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b1;
            if (mem_write) line_q <= mem_wdata;
            if (mem_read && mem_write) err_q <= 1'b1;
            state_q <= (LATENCY == 0) ? BURST : ACCESS;
          end
        end
        ACCESS: begin
          if (!req_ok) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (lat_cnt_q == LAT_LAST) begin
            word_cnt_q <= '0;
            state_q    <= BURST;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        BURST: begin
          if (!req_ok) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (!op_wr_q) line_q <= line_fill;
            if (word_cnt_q == WORD_LAST) begin
              if (!op_wr_q) rdata_q <= line_fill;
              resp_q  <= 1'b1;
              state_q <= RESP;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        RESP:    state_q <= GAP;
        GAP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign ca_resp   = resp_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - directed scoreboard bench for main_mem_responder (LATENCY 4 and 0)
module tb_main_mem_responder;
  import mem_pkg::*;

  logic         clk;
  logic         rst;
  logic         rd_m, wr_m, resp_m, busy_m, err_m;
  logic [31:0]  addr_m;
  logic [255:0] wd_m, rdata_m;
  logic         rd_z, wr_z, resp_z, busy_z, err_z;
  logic [31:0]  addr_z;
  logic [255:0] wd_z, rdata_z;

  main_mem_responder dut (
    .clk(clk), .rst(rst), .mem_read(rd_m), .mem_write(wr_m), .mem_addr(addr_m),
    .mem_wdata(wd_m), .mem_rdata(rdata_m), .ca_resp(resp_m), .busy(busy_m), .err(err_m)
  );

  main_mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd_z), .mem_write(wr_z), .mem_addr(addr_z),
    .mem_wdata(wd_z), .mem_rdata(rdata_z), .ca_resp(resp_z), .busy(busy_z), .err(err_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cur = 0;
  int resp_cnt = 0;
  logic [255:0] exp_q [$];
  logic [31:0]  model [2][8192];

  logic         s_resp, s_busy, s_err;
  logic [255:0] s_rdata;
  always_comb begin
    s_resp  = (cur != 0) ? resp_z  : resp_m;
    s_busy  = (cur != 0) ? busy_z  : busy_m;
    s_err   = (cur != 0) ? err_z   : err_m;
    s_rdata = (cur != 0) ? rdata_z : rdata_m;
  end

  always @(negedge clk) if (resp_m) resp_cnt++;

  task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] model_line(input int c, input int idx);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = model[c][idx*8+i];
    return l;
  endfunction

  task automatic model_write(input int idx, input logic [255:0] d);
    for (int i = 0; i < 8; i++) model[cur][idx*8+i] = d[i*32 +: 32];
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] d);
    if (cur == 0) begin
      rd_m = rd; wr_m = wr; addr_m = a; wd_m = d;
    end else begin
      rd_z = rd; wr_z = wr; addr_z = a; wd_z = d;
    end
  endtask

  // Called #1 after a rising edge with the responder idle; returns the same way.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [255:0] d, input string tag);
    int k;
    bit got;
    int idx;
    logic [255:0] e;
    idx = int'(line_index(a));
    drive(rd, wr, a, d);
    if (wr) model_write(idx, d);
    else exp_q.push_back(model_line(cur, idx));
    @(posedge clk); #1;
    drive(rd, wr, a, ~d);
    k = 0; got = 0;
    while (!got && k < 40) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (s_resp) got = 1;
    end
    chk(256'(k), 256'((cur != 0) ? 8 : 12), {tag, "_lat"});
    if (!wr) begin
      e = exp_q.pop_front();
      if (got) chk(s_rdata, e, {tag, "_rdata"});
    end
    @(posedge clk); #1;
    drive(0, 0, a, d);
    @(negedge clk);
    chk(256'(s_resp), 256'(0), {tag, "_pulse"});
    @(posedge clk); @(negedge clk);
    chk(256'(s_busy), 256'(0), {tag, "_idle"});
    @(posedge clk); #1;
  endtask

  initial begin
    int k, r0, nb;
    logic [255:0] e;
    rst = 1'b0;
    rd_m = 0; wr_m = 0; addr_m = '0; wd_m = '0;
    rd_z = 0; wr_z = 0; addr_z = '0; wd_z = '0;
    #1 rst = 1'b1;
    #6;
    chk(256'(resp_m), 256'(0), "rst_resp");
    chk(256'(busy_m), 256'(0), "rst_busy");
    chk(256'(err_m), 256'(0), "rst_err");
    chk(rdata_m, 256'(0), "rst_rdata");
    #5 rst = 1'b0;
    @(posedge clk); #1;

    run_txn(0, 1, 32'h0000_00A0, pat(32'h1000_0000), "pre5");
    run_txn(1, 0, 32'h0000_00A0, '0, "rd5");

    run_txn(0, 1, 32'h0000_0020, pat(32'h1111_0000), "wr1");
    run_txn(0, 1, 32'h0000_0060, pat(32'h3333_0000), "wr3");
    run_txn(0, 1, 32'h0000_0040, pat(32'hDEAD_0000), "wr2");
    run_txn(1, 0, 32'h0000_0040, '0, "rd2");
    run_txn(1, 0, 32'h0000_0020, '0, "rd1");
    run_txn(1, 0, 32'h0000_0060, '0, "rd3");
    chk(256'(err_m), 256'(0), "no_err");

    // Cache write-back then fill, read held one cycle past its ca_resp.
    r0 = resp_cnt;
    drive(0, 1, 32'h0000_00E0, pat(32'h7777_0000));
    model_write(7, pat(32'h7777_0000));
    k = 0;
    while (!resp_m && k < 40) begin @(posedge clk); k++; @(negedge clk); end
    @(posedge clk); #1;
    drive(1, 0, 32'h0000_00E0, '0);
    exp_q.push_back(model_line(0, 7));
    k = 0;
    do begin @(posedge clk); k++; @(negedge clk); end while (!resp_m && k < 40);
    chk(256'(k), 256'(14), "seq_rd_lat");
    e = exp_q.pop_front();
    chk(rdata_m, e, "seq_rdata");
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(0, 0, 32'h0000_00E0, '0);
    nb = 0;
    repeat (20) begin @(negedge clk); if (busy_m) nb++; end
    chk(256'(nb), 256'(0), "seq_no_third");
    chk(256'(resp_cnt - r0), 256'(2), "seq_two_resp");
    chk(256'(err_m), 256'(0), "seq_err");
    @(posedge clk); #1;

    // Abort a read three words into its burst.
    drive(1, 0, 32'h0000_00A0, '0);
    @(posedge clk);
    repeat (4) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 drive(0, 0, 32'h0000_00A0, '0);
    r0 = resp_cnt;
    @(posedge clk); @(negedge clk);
    chk(256'(err_m), 256'(1), "abort_err");
    chk(256'(busy_m), 256'(0), "abort_idle");
    chk(rdata_m, pat(32'h7777_0000), "abort_rdata");
    repeat (15) @(negedge clk);
    chk(256'(resp_cnt - r0), 256'(0), "abort_no_resp");
    @(posedge clk); #1;

    rst = 1'b1; #3 rst = 1'b0;
    @(posedge clk); #1;
    run_txn(1, 1, 32'h0000_8020, pat(32'hC0DE_0000), "conf");
    chk(256'(err_m), 256'(1), "conf_err");
    run_txn(1, 0, 32'h0000_0020, '0, "conf_rd1");

    // Asynchronous reset while in ACCESS.
    drive(1, 0, 32'h0000_0020, '0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk(256'(resp_m), 256'(0), "arst_resp");
    chk(256'(busy_m), 256'(0), "arst_busy");
    chk(256'(err_m), 256'(0), "arst_err");
    drive(0, 0, 32'h0000_0020, '0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_txn(1, 0, 32'h0000_0020, '0, "arst_rd1");
    run_txn(1, 0, 32'h0000_0040, '0, "arst_rd2");

    cur = 1;
    run_txn(1, 1, 32'h0000_8020, pat(32'hABCD_0000), "z_conf");
    chk(256'(err_z), 256'(1), "z_err");
    run_txn(1, 0, 32'h0000_0020, '0, "z_rd1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
